// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: self-test sequencer for one N_IN-input logic gate.
// Sweeps GATE_IN over every combination, holds each one SETTLE+1 cycles,
// samples GATE_OUT into TT and compares the result against EXP.
// Ports: CLK, RST (async, active-high), START, GATE_OUT in;
//        GATE_IN[N_IN], BUSY, DONE, PASS, TT[2**N_IN], ERR_IDX[N_IN] out.
// Option: define GATE_SWEEP_STOP_ON_FAIL_EN to end the sweep at the
//         first mismatching combination.
module gate_sweep_ctrl #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] EXP    = 4'b1000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 GATE_OUT,
    output logic [N_IN-1:0]      GATE_IN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [2**N_IN-1:0]   TT,
    output logic [N_IN-1:0]      ERR_IDX
);

    localparam int              NC       = 2**N_IN;
    localparam logic [3:0]      CNT_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            fail_q, fail_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [NC-1:0]   tt_q, tt_d;
    logic [N_IN-1:0] err_q, err_d;
    logic            mm;
    logic            finish;

    // Current sample disagrees with the expected table entry.
    assign mm = (GATE_OUT != EXP[idx_q]);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign finish = mm || (idx_q == IDX_LAST);
`else
    assign finish = (idx_q == IDX_LAST);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tt_d    = tt_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    idx_d   = '0;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                    tt_d    = '0;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                tt_d[idx_q] = GATE_OUT;
                if (mm && !fail_q) begin
                    fail_d = 1'b1;
                    err_d  = idx_q;
                end
                if (finish) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = ~(fail_q | mm);
                    state_d = S_FIN;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tt_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
        end
    end

    // The gate is driven straight from the sweep index register.
    assign GATE_IN = idx_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign PASS    = pass_q;
    assign TT      = tt_q;
    assign ERR_IDX = err_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: scoreboard bench for gate_sweep_ctrl (defaults).
// Stimulus pushes expected sweep results; a DONE monitor pops and checks.
module tb_gate_sweep_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       GATE_OUT;
    logic [1:0] GATE_IN;
    logic       BUSY;
    logic       DONE;
    logic       PASS;
    logic [3:0] TT;
    logic [1:0] ERR_IDX;

    logic       use_or = 1'b0;

    typedef struct {
        logic       pass;
        logic [3:0] tt;
        logic [1:0] err;
        int         lat;
        int         gap;
    } exp_t;

    exp_t sb[$];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int last_done = 0;
    logic busy_prev = 1'b0;

    gate_sweep_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .GATE_OUT (GATE_OUT),
        .GATE_IN  (GATE_IN),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PASS     (PASS),
        .TT       (TT),
        .ERR_IDX  (ERR_IDX)
    );

    always #5 CLK = ~CLK;

    // Gate under test: AND or OR of the two driven inputs.
    always_comb begin
        GATE_OUT = use_or ? (GATE_IN[1] | GATE_IN[0])
                          : (GATE_IN[1] & GATE_IN[0]);
    end

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [3:0] t,
                        input logic [1:0] e, input int l, input int g);
        exp_t x;
        x.pass = p;
        x.tt   = t;
        x.err  = e;
        x.lat  = l;
        x.gap  = g;
        sb.push_back(x);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge CLK);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        repeat (4) @(negedge CLK);
    endtask

    // Monitor: tracks accept edges via BUSY rise, checks each DONE.
    always @(negedge CLK) begin
        if (RST) begin
            busy_prev = 1'b0;
        end else begin
            exp_t e;
            cyc++;
            if (BUSY && !busy_prev) begin
                acc_cyc = cyc;
                check("accept_tt_clr", int'(TT), 0);
                check("accept_pass_clr", int'(PASS), 0);
                check("accept_err_clr", int'(ERR_IDX), 0);
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    check("spurious_done", int'(DONE), 0);
                end else begin
                    e = sb.pop_front();
                    check("pass", int'(PASS), int'(e.pass));
                    check("tt", int'(TT), int'(e.tt));
                    check("err_idx", int'(ERR_IDX), int'(e.err));
                    check("latency", cyc - acc_cyc, e.lat);
                    check("busy_at_done", int'(BUSY), 0);
                    if (e.gap != 0) begin
                        check("done_gap", cyc - last_done, e.gap);
                    end
                end
                last_done = cyc;
            end
            busy_prev = BUSY;
        end
    end

    initial begin
        repeat (3) @(negedge CLK);
        check("rst_gate_in", int'(GATE_IN), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_pass", int'(PASS), 0);
        check("rst_tt", int'(TT), 0);
        check("rst_err", int'(ERR_IDX), 0);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // AND gate, default EXP: clean pass.
        use_or = 1'b0;
        push(1'b1, 4'b1000, 2'd0, 12, 0);
        pulse_start();
        drain(40);
        check("and_hold_gate_in", int'(GATE_IN), 3);

        // OR gate against AND table.
        use_or = 1'b1;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        push(1'b0, 4'b0010, 2'd1, 6, 0);
`else
        push(1'b0, 4'b1110, 2'd1, 12, 0);
`endif
        pulse_start();
        drain(40);
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
        check("or_hold_gate_in", int'(GATE_IN), 1);
`else
        check("or_hold_gate_in", int'(GATE_IN), 3);
`endif

        // Reset 5 cycles into a sweep: everything clears, no DONE.
        use_or = 1'b0;
        pulse_start();
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_gate_in", int'(GATE_IN), 0);
        check("mid_rst_busy", int'(BUSY), 0);
        check("mid_rst_done", int'(DONE), 0);
        check("mid_rst_pass", int'(PASS), 0);
        check("mid_rst_tt", int'(TT), 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        push(1'b1, 4'b1000, 2'd0, 12, 0);
        pulse_start();
        drain(40);

        // Extra START pulses mid-sweep are ignored.
        push(1'b1, 4'b1000, 2'd0, 12, 0);
        pulse_start();
        repeat (2) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (7) @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        drain(40);
        repeat (16) @(negedge CLK);
        check("ignored_start_idle", int'(BUSY), 0);

        // START held: back-to-back sweeps 14 cycles apart.
        use_or = 1'b0;
        push(1'b1, 4'b1000, 2'd0, 12, 0);
        push(1'b1, 4'b1000, 2'd0, 12, 14);
        push(1'b1, 4'b1000, 2'd0, 12, 14);
        @(negedge CLK);
        START = 1'b1;
        repeat (36) @(negedge CLK);
        START = 1'b0;
        drain(60);
        repeat (16) @(negedge CLK);
        check("held_stop_busy", int'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Self-test sequencer for a single N-input logic gate instance, e.g. the 2-input AND gate.
- Drives the gate inputs through every input combination, waits a settle interval, and samples the gate output.
- Builds the observed truth table and compares it against an expected table.
- Sits beside the gate as its only driver; it replaces hand-written stimulus sequences in gate-level self-check.

Parameters:
- N_IN, 2: number of gate inputs; the sweep covers 2**N_IN combinations; legal range 1..4.
- SETTLE, 2: cycles GATE_IN is held before GATE_OUT is sampled; legal range 1..15.
- EXP, 4'b1000: expected truth table, width 2**N_IN; bit i = expected GATE_OUT when GATE_IN == i; the default is AND.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  sweep request; sampled only in IDLE.
- GATE_OUT  in  1  output of the gate under test.
- GATE_IN  out  N_IN  drives the gate inputs; GATE_IN[N_IN-1] is input A (MSB), GATE_IN[0] is the last input (B for N_IN=2).
- BUSY  out  1  high from the START-accept edge until the sweep ends.
- DONE  out  1  single-cycle pulse at the end of a sweep.
- PASS  out  1  1 if the observed table matched EXP; held until the next START.
- TT  out  2**N_IN  observed truth table; held until the next START.
- ERR_IDX  out  N_IN  lowest combination index that mismatched; 0 on pass.

Behaviour:
- Reset (RST=1, asynchronous): state=IDLE; GATE_IN, BUSY, DONE, PASS, TT, ERR_IDX, internal idx, cnt and fail all 0. RST mid-sweep aborts immediately; no DONE is produced.
- All outputs are registered.
- IDLE:
  - On START=1: idx=0, GATE_IN=0, cnt=0, fail=0, TT=0, PASS=0, ERR_IDX=0, BUSY=1; go to WAIT.
- WAIT:
  - cnt increments each cycle.
  - When cnt==SETTLE-1, go to SAMPLE. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - TT[idx] <= GATE_OUT.
  - If GATE_OUT != EXP[idx] and fail==0: fail=1, ERR_IDX=idx.
  - If idx==2**N_IN-1: DONE<=1, BUSY<=0, PASS<=~(fail or current mismatch); go to FIN.
  - Otherwise: idx<=idx+1, GATE_IN<=idx+1, cnt<=0; go to WAIT.
- FIN (1 cycle):
  - DONE is high in this cycle only.
  - DONE<=0 on exit; go to IDLE.
- START rules:
  - START is ignored in WAIT, SAMPLE and FIN; it is not queued.
  - If START is held high, a new sweep is accepted on the first IDLE edge after FIN.
- Latency: DONE is high in the cycle beginning (2**N_IN)*(SETTLE+1) edges after the START-accept edge. With defaults this is 12.
- GATE_IN holds its last value (2**N_IN-1) after the sweep until the next START.
- Each GATE_IN value is stable for exactly SETTLE+1 cycles. GATE_OUT is sampled at the end of that window.

Optional Feature:
- Macro: GATE_SWEEP_STOP_ON_FAIL_EN.
- Defined: in SAMPLE, the first mismatch ends the sweep immediately (DONE, BUSY=0, PASS=0, go to FIN). TT bits for unvisited combinations remain 0, and ERR_IDX = the failing idx. DONE latency becomes (ERR_IDX+1)*(SETTLE+1) on fail; pass latency is unchanged.
- Undefined: the full sweep always runs.

Test Plan:
- AND gate model, defaults, START pulsed 1 cycle -> GATE_IN steps 0,1,2,3 with 3 cycles each; DONE pulses 12 cycles after accept; PASS=1, TT=4'b1000, ERR_IDX=0; BUSY high for 12 cycles.
- OR gate model, EXP=4'b1000, macro undefined -> DONE at 12 cycles; PASS=0, TT=4'b1110, ERR_IDX=1.
- Same OR model with GATE_SWEEP_STOP_ON_FAIL_EN defined -> DONE 6 cycles after accept; PASS=0, TT=4'b0010, ERR_IDX=1; GATE_IN stays at 1.
- RST asserted for 1 cycle, 5 cycles into a sweep -> all outputs 0 immediately; no DONE; a later START runs a full clean sweep with PASS=1.
- START pulsed again at cycles 3 and 11 of a sweep -> ignored; exactly one DONE.
- START held high continuously -> consecutive sweeps with DONE pulses 14 cycles apart (FIN + IDLE gap); TT and PASS are cleared on each accept.
